softmax_arith_core: RTL and testbench

- Bundles the three integer arithmetic kernels of the integer-only softmax datapath: accumulator (acc), sequential divider (div), and polynomial exponential approximator (exp).
- The three channels are independent. They share only clock, reset and the global enable (stall).
- Sits between the max/subtract stage and the output scaler. exp produces exp(q - qmax), acc sums the rescaled exponentials, and div computes 2^MAX_BITS / sum.

---
 rtl/softmax_arith_core_if.sv | 55 +++++
 rtl/softmax_arith_core.sv | 208 ++++++++++++++++++++
 tb/tb_softmax_arith_core.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_arith_core_if.sv
// Bundle of the three softmax arithmetic channels (acc, div, exp).
// The master modport drives operands, the slave modport is the core.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero flag to the bundle.
interface softmax_arith_core_if #(
    parameter int D_W = 32
);
    // acc channel
    logic                  acc_init;
    logic signed [D_W-1:0] acc_in;
    logic signed [D_W-1:0] acc_result;

    // div channel
    logic                  div_in_valid;
    logic        [D_W-1:0] div_divisor;
    logic        [D_W-1:0] div_dividend;
    logic                  div_out_valid;
    logic        [D_W-1:0] div_quotient;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_zero;
`endif

    // exp channel
    logic                  exp_in_valid;
    logic signed [D_W-1:0] exp_qin;
    logic signed [D_W-1:0] exp_qb;
    logic signed [D_W-1:0] exp_qc;
    logic signed [D_W-1:0] exp_qln2;
    logic signed [D_W-1:0] exp_qln2_inv;
    logic                  exp_out_valid;
    logic signed [D_W-1:0] exp_qout;

    modport master (
        output acc_init, acc_in,
        input  acc_result,
        output div_in_valid, div_divisor, div_dividend,
        input  div_out_valid, div_quotient,
`ifdef DIV_ZERO_FLAG_EN
        input  div_zero,
`endif
        output exp_in_valid, exp_qin, exp_qb, exp_qc, exp_qln2, exp_qln2_inv,
        input  exp_out_valid, exp_qout
    );

    modport slave (
        input  acc_init, acc_in,
        output acc_result,
        input  div_in_valid, div_divisor, div_dividend,
        output div_out_valid, div_quotient,
`ifdef DIV_ZERO_FLAG_EN
        output div_zero,
`endif
        input  exp_in_valid, exp_qin, exp_qb, exp_qc, exp_qln2, exp_qln2_inv,
        output exp_out_valid, exp_qout
    );
endinterface

// File: rtl/softmax_arith_core.sv
// Integer softmax arithmetic kernels: accumulator, restoring divider and
// 4-stage polynomial exponential. Channels are independent and share only
// clk, the asynchronous active-low rst and the global enable (stall).
// Optional macro DIV_ZERO_FLAG_EN: drive div_zero alongside div_out_valid
// when the latched divisor was zero.
module softmax_arith_core #(
    parameter int D_W     = 32,
    parameter int FP_BITS = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    softmax_arith_core_if.slave  bus
);
    localparam int W2    = 2 * D_W;
    localparam int CNT_W = $clog2(D_W);
    localparam int SH_W  = $clog2(W2);
    localparam logic signed [W2-1:0] SHIFT_LIM = W2'(W2);

    // ------------------------------------------------------------------
    // acc
    // ------------------------------------------------------------------
    logic signed [D_W-1:0] acc_reg;

    // Running sum: load on acc_init, otherwise wrap-around add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_reg <= '0;
        else if (enable)
            acc_reg <= bus.acc_init ? bus.acc_in : acc_reg + bus.acc_in;
    end

    assign bus.acc_result = acc_reg;

    // ------------------------------------------------------------------
    // div
    // ------------------------------------------------------------------
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    div_state_t        div_state_reg, div_state_next;
    logic [D_W-1:0]    rem_reg, rem_next;
    logic [D_W-1:0]    quo_reg, quo_next;      // dividend shifts out, quotient shifts in
    logic [D_W-1:0]    dvs_reg, dvs_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              dout_valid_reg, dout_valid_next;
    logic [D_W-1:0]    dquot_reg, dquot_next;
    logic [D_W:0]      rem_shift;
    logic [D_W-1:0]    rem_sub;
`ifdef DIV_ZERO_FLAG_EN
    logic              zero_reg, zero_next;
`endif

    // Divider state and datapath registers, frozen while enable is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_state_reg  <= DIV_IDLE;
            rem_reg        <= '0;
            quo_reg        <= '0;
            dvs_reg        <= '0;
            cnt_reg        <= '0;
            dout_valid_reg <= 1'b0;
            dquot_reg      <= '0;
`ifdef DIV_ZERO_FLAG_EN
            zero_reg       <= 1'b0;
`endif
        end else if (enable) begin
            div_state_reg  <= div_state_next;
            rem_reg        <= rem_next;
            quo_reg        <= quo_next;
            dvs_reg        <= dvs_next;
            cnt_reg        <= cnt_next;
            dout_valid_reg <= dout_valid_next;
            dquot_reg      <= dquot_next;
`ifdef DIV_ZERO_FLAG_EN
            zero_reg       <= zero_next;
`endif
        end
    end

    // Next-state: latch operands in IDLE, one restoring step per BUSY cycle
    always_comb begin
        div_state_next  = div_state_reg;
        rem_next        = rem_reg;
        quo_next        = quo_reg;
        dvs_next        = dvs_reg;
        cnt_next        = cnt_reg;
        dout_valid_next = 1'b0;
        dquot_next      = dquot_reg;
`ifdef DIV_ZERO_FLAG_EN
        zero_next       = 1'b0;
`endif
        rem_shift       = {rem_reg, quo_reg[D_W-1]};
        rem_sub         = rem_shift[D_W-1:0] - dvs_reg;
        case (div_state_reg)
            DIV_IDLE: begin
                if (bus.div_in_valid) begin
                    div_state_next = DIV_BUSY;
                    rem_next       = '0;
                    quo_next       = bus.div_dividend;
                    dvs_next       = bus.div_divisor;
                    cnt_next       = '0;
                end
            end
            DIV_BUSY: begin
                // A zero divisor always "fits", producing an all-ones quotient
                if (rem_shift >= {1'b0, dvs_reg}) begin
                    rem_next = rem_sub;
                    quo_next = {quo_reg[D_W-2:0], 1'b1};
                end else begin
                    rem_next = rem_shift[D_W-1:0];
                    quo_next = {quo_reg[D_W-2:0], 1'b0};
                end
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(D_W - 1)) begin
                    div_state_next  = DIV_IDLE;
                    dout_valid_next = 1'b1;
                    dquot_next      = quo_next;
`ifdef DIV_ZERO_FLAG_EN
                    zero_next       = (dvs_reg == '0);
`endif
                end
            end
            default: div_state_next = DIV_IDLE;
        endcase
    end

    assign bus.div_out_valid = dout_valid_reg;
    assign bus.div_quotient  = dquot_reg;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_zero      = zero_reg;
`endif

    // ------------------------------------------------------------------
    // exp
    // ------------------------------------------------------------------
    logic signed [W2-1:0]  qin_ext, inv_ext, s1_z_calc;
    logic signed [W2-1:0]  s2_p_calc, s3_t_calc, s3_poly_calc, s4_shift_calc;

    logic                  s1_valid_reg, s2_valid_reg, s3_valid_reg, out_valid_reg;
    logic signed [W2-1:0]  s1_qin_reg, s1_z_reg, s2_z_reg, s3_z_reg;
    logic signed [W2-1:0]  s2_p_reg, s3_poly_reg;
    logic signed [D_W-1:0] s1_qln2_reg, s1_qb_reg, s1_qc_reg, s2_qb_reg, s2_qc_reg;
    logic signed [D_W-1:0] qout_reg;

    // Stage arithmetic: range reduction, remainder, quadratic, shift
    always_comb begin
        qin_ext      = W2'(bus.exp_qin);
        inv_ext      = W2'(bus.exp_qln2_inv);
        s1_z_calc    = ((-qin_ext) * inv_ext) >>> FP_BITS;
        s2_p_calc    = s1_qin_reg + s1_z_reg * W2'(s1_qln2_reg);
        s3_t_calc    = s2_p_reg + W2'(s2_qb_reg);
        s3_poly_calc = s3_t_calc * s3_t_calc + W2'(s2_qc_reg);
        // Negative z (positive input) shifts by 0; oversized z underflows to 0
        if (s3_z_reg < 0)
            s4_shift_calc = s3_poly_reg;
        else if (s3_z_reg >= SHIFT_LIM)
            s4_shift_calc = '0;
        else
            s4_shift_calc = s3_poly_reg >>> s3_z_reg[SH_W-1:0];
    end

    // Pipeline registers; coefficients travel with their sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            s1_qin_reg    <= '0;
            s1_z_reg      <= '0;
            s2_z_reg      <= '0;
            s3_z_reg      <= '0;
            s2_p_reg      <= '0;
            s3_poly_reg   <= '0;
            s1_qln2_reg   <= '0;
            s1_qb_reg     <= '0;
            s1_qc_reg     <= '0;
            s2_qb_reg     <= '0;
            s2_qc_reg     <= '0;
            qout_reg      <= '0;
        end else if (enable) begin
            s1_valid_reg  <= bus.exp_in_valid;
            s1_qin_reg    <= qin_ext;
            s1_z_reg      <= s1_z_calc;
            s1_qln2_reg   <= bus.exp_qln2;
            s1_qb_reg     <= bus.exp_qb;
            s1_qc_reg     <= bus.exp_qc;

            s2_valid_reg  <= s1_valid_reg;
            s2_p_reg      <= s2_p_calc;
            s2_z_reg      <= s1_z_reg;
            s2_qb_reg     <= s1_qb_reg;
            s2_qc_reg     <= s1_qc_reg;

            s3_valid_reg  <= s2_valid_reg;
            s3_poly_reg   <= s3_poly_calc;
            s3_z_reg      <= s2_z_reg;

            out_valid_reg <= s3_valid_reg;
            if (s3_valid_reg)
                qout_reg <= s4_shift_calc[D_W-1:0];
        end
    end

    assign bus.exp_out_valid = out_valid_reg;
    assign bus.exp_qout      = qout_reg;

endmodule

// File: tb/tb_softmax_arith_core.sv
// Directed testbench for softmax_arith_core with hand-computed expectations.
// Honors DIV_ZERO_FLAG_EN when the design is built with it.
module tb_softmax_arith_core;
    logic clk;
    logic rst;
    logic enable;
    int   n_checks;
    int   n_fail;

    softmax_arith_core_if #(.D_W(32)) bus ();

    softmax_arith_core #(.D_W(32), .FP_BITS(30)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a division and count enabled edges until the result pulse
    task automatic run_div(input logic [31:0] dd, input logic [31:0] dv,
                           input logic [31:0] expq, input bit zero_exp,
                           input bit gap, input string tag);
        int  n;
        bit  seen;
        bus.div_in_valid = 1'b1;
        bus.div_dividend = dd;
        bus.div_divisor  = dv;
        tick();
        bus.div_in_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (gap && n == 10) begin
                enable = 1'b0;
                repeat (5) tick();
                enable = 1'b1;
            end
            tick();
            n++;
            if (bus.div_out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_quot"}, 64'(bus.div_quotient), 64'(expq));
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_zero"}, 64'(bus.div_zero), 64'(zero_exp));
`else
        if (zero_exp) n = n;
`endif
        tick();
        check({tag, "_pulse_end"}, 64'(bus.div_out_valid), 64'd0);
        check({tag, "_hold"}, 64'(bus.div_quotient), 64'(expq));
    endtask

    // Single exp sample; valid must appear exactly 4 enabled edges later
    task automatic run_exp(input int qin, input int qb, input int qc,
                           input int qln2, input int inv, input int expq,
                           input string tag);
        bus.exp_in_valid = 1'b1;
        bus.exp_qin      = qin;
        bus.exp_qb       = qb;
        bus.exp_qc       = qc;
        bus.exp_qln2     = qln2;
        bus.exp_qln2_inv = inv;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.exp_in_valid = 1'b0;
            check($sformatf("%s_valid_e%0d", tag, k), 64'(bus.exp_out_valid), 64'(k == 4));
        end
        check({tag, "_qout"}, 64'(bus.exp_qout), 64'(expq));
    endtask

    int exp_qin_v [8] = '{0, -2000, -500, -2500, -3700, -1000, -7200, -100000};
    int exp_out_v [8] = '{105, 490052, 240105, 60026, 59513, 980105, 282, 0};

    initial begin
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        bus.acc_init     = 1'b0;
        bus.acc_in       = '0;
        bus.div_in_valid = 1'b0;
        bus.div_dividend = '0;
        bus.div_divisor  = '0;
        bus.exp_in_valid = 1'b0;
        bus.exp_qin      = '0;
        bus.exp_qb       = '0;
        bus.exp_qc       = '0;
        bus.exp_qln2     = '0;
        bus.exp_qln2_inv = '0;

        // Reset state
        repeat (2) tick();
        check("rst_acc", 64'(bus.acc_result), 64'd0);
        check("rst_div_valid", 64'(bus.div_out_valid), 64'd0);
        check("rst_div_quot", 64'(bus.div_quotient), 64'd0);
        check("rst_exp_valid", 64'(bus.exp_out_valid), 64'd0);
        check("rst_exp_qout", 64'(bus.exp_qout), 64'd0);
        rst    = 1'b1;
        enable = 1'b1;

        // acc: load 5, then add 7, -3, 100
        bus.acc_init = 1'b1; bus.acc_in = 5;
        tick(); check("acc_init5", 64'(bus.acc_result), 64'd5);
        bus.acc_init = 1'b0; bus.acc_in = 7;
        tick(); check("acc_add7", 64'(bus.acc_result), 64'd12);
        bus.acc_in = -3;
        tick(); check("acc_sub3", 64'(bus.acc_result), 64'd9);
        bus.acc_in = 100;
        tick(); check("acc_add100", 64'(bus.acc_result), 64'd109);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("acc_hold%0d", k), 64'(bus.acc_result), 64'd109);
        end
        bus.acc_in = 0;
        enable = 1'b1;
        tick();
        check("acc_after_hold", 64'(bus.acc_result), 64'd109);

        // div: basic results and divide-by-zero
        run_div(32'd1073741824, 32'd1024, 32'd1048576, 1'b0, 1'b0, "div_1024");
        run_div(32'd1073741824, 32'd3, 32'd357913941, 1'b0, 1'b0, "div_3");
        run_div(32'd12345, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_by0");
        run_div(32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "div_gap");

        // div: second request while BUSY is ignored
        bus.div_in_valid = 1'b1;
        bus.div_dividend = 32'd1073741824;
        bus.div_divisor  = 32'd1024;
        tick();
        bus.div_in_valid = 1'b0;
        repeat (4) tick();
        bus.div_in_valid = 1'b1;
        bus.div_divisor  = 32'd3;
        tick();
        bus.div_in_valid = 1'b0;
        begin
            int n;
            n = 5;
            while (!bus.div_out_valid && n < 100) begin
                tick();
                n++;
            end
            check("div_busy_latency", 64'(n), 64'd32);
            check("div_busy_quot", 64'(bus.div_quotient), 64'd1048576);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.div_out_valid) pulses++;
        end
        check("div_busy_no_second", 64'(pulses), 64'd0);

        // exp: single samples
        run_exp(0, 10, 5, 1000, 1073741, 105, "exp_zero");
        run_exp(-2000, 0, 0, 1000, 1073741, 500000, "exp_m2000");
        run_exp(500, 10, 5, 1000, 1073741, 240105, "exp_pos");

        // exp: 8 back-to-back samples
        bus.exp_qb = 10; bus.exp_qc = 5; bus.exp_qln2 = 1000; bus.exp_qln2_inv = 1073741;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 8) begin
                bus.exp_in_valid = 1'b1;
                bus.exp_qin      = exp_qin_v[c-1];
            end else begin
                bus.exp_in_valid = 1'b0;
            end
            tick();
            check($sformatf("exp_burst_valid_e%0d", c), 64'(bus.exp_out_valid),
                  64'(c >= 4 && c <= 11));
            if (c >= 4 && c <= 11)
                check($sformatf("exp_burst_qout%0d", c - 4), 64'(bus.exp_qout),
                      64'(exp_out_v[c-4]));
        end

        // exp: an enable gap delays outputs by the same gap
        begin
            bit en_v [8]  = '{1, 1, 0, 0, 1, 1, 1, 1};
            bit vin_v [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
            bit vout_v [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
            int qin_v [8] = '{500, -2000, -7200, -7200, 0, 0, 0, 0};
            for (int c = 0; c < 8; c++) begin
                enable           = en_v[c];
                bus.exp_in_valid = vin_v[c];
                bus.exp_qin      = qin_v[c];
                tick();
                check($sformatf("exp_gap_valid_c%0d", c), 64'(bus.exp_out_valid), 64'(vout_v[c]));
                if (c == 5) check("exp_gap_qout_a", 64'(bus.exp_qout), 64'd240105);
                if (c == 6) check("exp_gap_qout_b", 64'(bus.exp_qout), 64'd490052);
            end
            enable           = 1'b1;
            bus.exp_in_valid = 1'b0;
        end

        // Reset during a division aborts it and clears outputs at once
        bus.div_in_valid = 1'b1;
        bus.div_dividend = 32'd1073741824;
        bus.div_divisor  = 32'd3;
        tick();
        bus.div_in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_acc", 64'(bus.acc_result), 64'd0);
        check("mid_rst_quot", 64'(bus.div_quotient), 64'd0);
        check("mid_rst_exp_qout", 64'(bus.exp_qout), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.div_out_valid) pulses++;
        end
        check("mid_rst_no_pulse", 64'(pulses), 64'd0);
        check("mid_rst_quot_after", 64'(bus.div_quotient), 64'd0);
        run_div(32'd1073741824, 32'd3, 32'd357913941, 1'b0, 1'b0, "div_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
